// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive path.
//   - rx_state_t : receiver FSM state encodings
//   - MID_FIRST / MID_LAST / BIT_END : tick positions within one bit
//   - DB_* : cfg_data_bits encodings, plus a helper that maps them to the
//     index of the last data bit
package uart_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [3:0] MID_FIRST = 4'd7;
    localparam logic [3:0] MID_MID   = 4'd8;
    localparam logic [3:0] MID_LAST  = 4'd9;
    localparam logic [3:0] BIT_END   = 4'd15;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    // Index of the final data bit for a given data-bits encoding.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
        case (db)
            DB_5:    return 3'd4;
            DB_6:    return 3'd5;
            DB_7:    return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-input synchroniser and mid-bit majority voter.
//   clk_i, rst_i : clock, async active-high reset
//   tick_i       : 16x oversample tick
//   rxd_i        : raw asynchronous serial line
//   cnt_i        : tick position within the current bit
//   rxs_o        : synchronised line value
//   vote_o       : majority of rxs at ticks 7, 8 and 9; valid while cnt_i == 9
module uart_rx_sync
    import uart_rx_deserializer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       rxd_i,
    input  logic [3:0] cnt_i,
    output logic       rxs_o,
    output logic       vote_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s7_q;
    logic                   s8_q;

    // Line idles high, so reset the chain to 1 to avoid a phantom start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxs_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else if (tick_i) begin
            if (cnt_i == MID_FIRST) s7_q <= rxs_o;
            if (cnt_i == MID_MID)   s8_q <= rxs_o;
        end
    end

    // Third sample is the live rxs at the decision tick.
    assign vote_o = (s7_q & s8_q) | (s7_q & rxs_o) | (s8_q & rxs_o);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start validation, data shift, parity and stop
// checks, one parallel byte per frame.
//   clk, rst         : clock, async active-high reset
//   rx_data_sample   : 16x oversample tick
//   rx_en            : receiver enable (low forces IDLE)
//   rxd              : serial line, idles high
//   cfg_*            : frame format, latched at the start bit
//   rx_data          : received word, unused upper bits 0
//   rx_valid         : one-clk pulse when rx_data/flags update
//   parity_err       : parity mismatch in last frame
//   frame_err        : a stop bit sampled low in last frame
//   rx_busy          : receiver not in IDLE
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_sample,
    input  logic       rx_en,
    input  logic       rxd,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [3:0] CNT_END = 4'(OVERSAMPLE - 1);

    rx_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       stop_sec_q, stop_sec_d;
    logic       brk_q, brk_d;
    logic [1:0] db_q, db_d;
    logic       pen_q, pen_d;
    logic       podd_q, podd_d;
    logic       stop2_q, stop2_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;

    logic rxs;
    logic vote;
    logic ferr_now;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_i (rx_data_sample),
        .rxd_i  (rxd),
        .cnt_i  (cnt_q),
        .rxs_o  (rxs),
        .vote_o (vote)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop_sec_q   <= 1'b0;
            brk_q        <= 1'b0;
            db_q         <= DB_8;
            pen_q        <= 1'b0;
            podd_q       <= 1'b0;
            stop2_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            stop_sec_q   <= stop_sec_d;
            brk_q        <= brk_d;
            db_q         <= db_d;
            pen_q        <= pen_d;
            podd_q       <= podd_d;
            stop2_q      <= stop2_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        stop_sec_d   = stop_sec_q;
        brk_d        = brk_q;
        db_d         = db_q;
        pen_d        = pen_q;
        podd_d       = podd_q;
        stop2_d      = stop2_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        ferr_now     = ferr_q | ~vote;

        if (!rx_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (rx_data_sample) begin
            cnt_d = cnt_q + 4'd1;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // After a break, wait for the line to go high once
                    // before trusting a low as a new start bit.
                    if (brk_q) begin
                        if (rxs) brk_d = 1'b0;
                    end else if (!rxs) begin
                        state_d    = ST_START;
                        shift_d    = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        stop_sec_d = 1'b0;
                        db_d       = cfg_data_bits;
                        pen_d      = cfg_parity_en;
                        podd_d     = cfg_parity_odd;
                        stop2_d    = cfg_stop2;
                    end
                end
                ST_START: begin
                    if (cnt_q == MID_LAST && vote) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_END) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == MID_LAST) shift_d[bit_idx_q] = vote;
                    if (cnt_q == CNT_END) begin
                        if (bit_idx_q == last_bit_idx(db_q)) begin
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    // Unused upper shift bits are 0, so a full-width XOR is safe.
                    if (cnt_q == MID_LAST) perr_d = (^shift_q) ^ vote ^ podd_q;
                    if (cnt_q == CNT_END)  state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (cnt_q == MID_LAST) begin
                        // Leave mid-stop-bit so an immediate next start edge is seen.
                        if (!stop2_q || stop_sec_q) begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shift_q;
                            parity_err_d = perr_q;
                            frame_err_d  = ferr_now;
                            brk_d        = ~vote;
                        end else begin
                            ferr_d = ferr_now;
                        end
                    end else if (cnt_q == CNT_END) begin
                        stop_sec_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_sample = 1'b0;
    logic       rx_en = 1'b1;
    logic       rxd = 1'b1;
    logic [1:0] cfg_data_bits = 2'b11;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int vectors = 0;
    int miscompares = 0;

    // Frame log captured from rx_valid pulses.
    int         vcount = 0;
    logic [7:0] log_d  [0:31];
    logic       log_pe [0:31];
    logic       log_fe [0:31];

    localparam int BITCLK = 48; // 16 ticks at one tick per 3 clk

    uart_rx_deserializer dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data_sample (rx_data_sample),
        .rx_en          (rx_en),
        .rxd            (rxd),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: one-clk tick every third clock.
    int div = 0;
    always @(negedge clk) begin
        if (div == 2) begin
            div = 0;
            rx_data_sample = 1'b1;
        end else begin
            div++;
            rx_data_sample = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            if (vcount < 32) begin
                log_d[vcount]  = rx_data;
                log_pe[vcount] = parity_err;
                log_fe[vcount] = frame_err;
            end
            vcount++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BITCLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input logic s1, input logic two,
                              input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rxd = 1'b1;
    endtask

    int v0;

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_data",  rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_pe",    parity_err, 1'b0);
        chk("rst_fe",    frame_err, 1'b0);
        chk("rst_busy",  rx_busy, 1'b0);
        rst = 1'b0;
        idle_bits(2);

        // 8N1 0x55
        v0 = vcount;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("t1_count", vcount, v0 + 1);
        chk("t1_data",  rx_data, 8'h55);
        chk("t1_pe",    parity_err, 1'b0);
        chk("t1_fe",    frame_err, 1'b0);

        // False start: 4 ticks low
        v0 = vcount;
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        chk("t2_busy_hi", rx_busy, 1'b1);
        repeat (BITCLK) @(negedge clk);
        chk("t2_busy_lo", rx_busy, 1'b0);
        chk("t2_count",   vcount, v0);

        // 7E1 0x41 with wrong then correct parity
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        v0 = vcount;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("t3a_count", vcount, v0 + 1);
        chk("t3a_data",  rx_data, 8'h41);
        chk("t3a_pe",    parity_err, 1'b1);
        chk("t3a_fe",    frame_err, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("t3b_count", vcount, v0 + 2);
        chk("t3b_data",  rx_data, 8'h41);
        chk("t3b_pe",    parity_err, 1'b0);

        // 8N2 0xA3, second stop low
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1;
        v0 = vcount;
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        chk("t4_count", vcount, v0 + 1);
        chk("t4_data",  rx_data, 8'hA3);
        chk("t4_fe",    frame_err, 1'b1);
        chk("t4_pe",    parity_err, 1'b0);

        // Break: line low for 20 bit times
        v0 = vcount;
        rxd = 1'b0;
        repeat (20 * BITCLK) @(negedge clk);
        chk("brk_count", vcount, v0 + 1);
        chk("brk_data",  rx_data, 8'h00);
        chk("brk_fe",    frame_err, 1'b1);
        chk("brk_busy",  rx_busy, 1'b0);
        idle_bits(3);
        chk("brk_after", vcount, v0 + 1);

        // Back-to-back 8N1
        cfg_stop2 = 1'b0;
        v0 = vcount;
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h56, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("b2b_count", vcount, v0 + 3);
        chk("b2b_d0", log_d[v0],     8'h12);
        chk("b2b_d1", log_d[v0 + 1], 8'h34);
        chk("b2b_d2", log_d[v0 + 2], 8'h56);
        chk("b2b_err0", {log_pe[v0],     log_fe[v0]},     2'b00);
        chk("b2b_err1", {log_pe[v0 + 1], log_fe[v0 + 1]}, 2'b00);
        chk("b2b_err2", {log_pe[v0 + 2], log_fe[v0 + 2]}, 2'b00);

        // rst during data bit 3 of 0xFF
        v0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        repeat (24) @(negedge clk);
        chk("mrst_busy_pre", rx_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", rx_busy, 1'b0);
        chk("mrst_data", rx_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        chk("mrst_count", vcount, v0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("mrst_count2", vcount, v0 + 1);
        chk("mrst_data2",  rx_data, 8'h0F);

        // rx_en drop during data bit 3 of 0xFF
        v0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        repeat (24) @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("men_busy", rx_busy, 1'b0);
        chk("men_hold", rx_data, 8'h0F);
        rx_en = 1'b1;
        idle_bits(2);
        chk("men_count", vcount, v0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("men_count2", vcount, v0 + 1);
        chk("men_data2",  rx_data, 8'h0F);
        chk("men_fe",     frame_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
